// File: rtl/uart_pkg.sv
// Shared definitions for the block transmit framer: FSM encoding, parameter
// defaults and the counter-width helper.
package uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_WAIT  = 2'd2,
      ST_GAP   = 2'd3
   } tx_state_e;

   localparam int DEF_NUM_BYTES      = 16;
   localparam int DEF_GAP_CYCLES     = 0;
   localparam int DEF_TIMEOUT_CYCLES = 0;

   // Width able to hold every value 0..limit with one bit of headroom.
   function automatic int cnt_width(input int limit);
      return $clog2(limit) + 1;
   endfunction

endpackage

// File: rtl/edge_rise_det.sv
// Rising-edge detector: rise_o is high while sig_i is high and its registered
// history was low, so a level held high fires only once.
module edge_rise_det (
   input  logic clk,
   input  logic reset,
   input  logic sig_i,
   output logic rise_o
);

   logic prev_q;

   // Previous-cycle sample of the monitored input.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prev_q <= 1'b0;
      end else begin
         prev_q <= sig_i;
      end
   end

   assign rise_o = sig_i & ~prev_q;

endmodule

// File: rtl/block_tx_framer.sv
// Splits a multi-byte block into single-byte requests for a UART transmitter,
// with optional inter-byte gap and per-byte completion timeout.
module block_tx_framer
   import uart_pkg::*;
#(
   parameter int NUM_BYTES      = DEF_NUM_BYTES,
   parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   blk_valid,
   input  logic [NUM_BYTES*8-1:0] blk_data,
   output logic                   blk_ready,
   output logic                   tx_start,
   output logic [7:0]             tx_data,
   input  logic                   tx_done,
   output logic                   busy,
   output logic                   blk_sent,
   output logic                   tx_err
);

   localparam int DW      = NUM_BYTES * 8;
   localparam int CNT_W   = cnt_width(NUM_BYTES);
   localparam int GAP_W   = cnt_width(GAP_CYCLES);
   localparam int TMR_W   = cnt_width(TIMEOUT_CYCLES);
   // The tx_start cycle counts towards the timeout, and tx_err is registered,
   // so the abort decision is taken two cycles short of the limit.
   localparam int TO_LAST = (TIMEOUT_CYCLES > 1) ? TIMEOUT_CYCLES - 2 : 0;

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BYTES - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_BYTES);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TO_LAST);

   tx_state_e        state_q;
   logic [DW-1:0]    shift_q;
   logic [DW-1:0]    shift_adv_s;
   logic [CNT_W-1:0] cnt_q;
   logic [GAP_W-1:0] gap_q;
   logic [TMR_W-1:0] tmr_q;
   logic             blk_ready_q;
   logic             tx_start_q;
   logic [7:0]       tx_data_q;
   logic             busy_q;
   logic             blk_sent_q;
   logic             tx_err_q;
   logic             done_rise_s;

   edge_rise_det u_done_edge (
      .clk    (clk),
      .reset  (reset),
      .sig_i  (tx_done),
      .rise_o (done_rise_s)
   );

   assign shift_adv_s = shift_q << 4'd8;

   // Framing FSM with all outputs registered alongside the state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         shift_q     <= '0;
         cnt_q       <= '0;
         gap_q       <= '0;
         tmr_q       <= '0;
         blk_ready_q <= 1'b0;
         tx_start_q  <= 1'b0;
         tx_data_q   <= 8'h00;
         busy_q      <= 1'b0;
         blk_sent_q  <= 1'b0;
         tx_err_q    <= 1'b0;
      end else begin
         tx_start_q <= 1'b0;
         blk_sent_q <= 1'b0;
         tx_err_q   <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               blk_ready_q <= 1'b1;
               busy_q      <= 1'b0;
               if (blk_valid && blk_ready_q) begin
                  shift_q     <= blk_data;
                  cnt_q       <= '0;
                  tx_data_q   <= blk_data[DW-1 -: 8];
                  tx_start_q  <= 1'b1;
                  blk_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  state_q     <= ST_START;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_START: begin
               tmr_q   <= '0;
               state_q <= ST_WAIT;
            end
            ST_WAIT: begin
               if (done_rise_s) begin
                  shift_q <= shift_adv_s;
                  cnt_q   <= cnt_q + 1'b1;
                  gap_q   <= '0;
                  if (cnt_q == LAST_IDX) begin
                     blk_sent_q <= 1'b1;
                  end else begin
                     blk_sent_q <= 1'b0;
                  end
                  if (GAP_CYCLES > 0) begin
                     state_q <= ST_GAP;
                  end else if (cnt_q == LAST_IDX) begin
                     blk_ready_q <= 1'b1;
                     busy_q      <= 1'b0;
                     state_q     <= ST_IDLE;
                  end else begin
                     tx_data_q  <= shift_adv_s[DW-1 -: 8];
                     tx_start_q <= 1'b1;
                     state_q    <= ST_START;
                  end
               end else if ((TIMEOUT_CYCLES > 0) && (tmr_q >= TMR_LAST)) begin
                  tx_err_q    <= 1'b1;
                  shift_q     <= '0;
                  cnt_q       <= '0;
                  blk_ready_q <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= ST_IDLE;
               end else if (TIMEOUT_CYCLES > 0) begin
                  tmr_q <= tmr_q + 1'b1;
               end else begin
                  tmr_q <= '0;
               end
            end
            ST_GAP: begin
               if (gap_q != GAP_LAST) begin
                  gap_q <= gap_q + 1'b1;
               end else if (cnt_q == CNT_FULL) begin
                  blk_ready_q <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= ST_IDLE;
               end else begin
                  tx_data_q  <= shift_q[DW-1 -: 8];
                  tx_start_q <= 1'b1;
                  state_q    <= ST_START;
               end
            end
            default: begin
               blk_ready_q <= 1'b1;
               busy_q      <= 1'b0;
               state_q     <= ST_IDLE;
            end
         endcase
      end
   end

   assign blk_ready = blk_ready_q;
   assign tx_start  = tx_start_q;
   assign tx_data   = tx_data_q;
   assign busy      = busy_q;
   assign blk_sent  = blk_sent_q;
   assign tx_err    = tx_err_q;

endmodule

// File: tb/tb_block_tx_framer.sv
// Directed bench: default 16-byte framer plus a 4-byte framer with a 3-cycle
// gap and a 50-cycle timeout, sharing clock and reset.
module tb_block_tx_framer;

   logic         clk = 1'b0;
   logic         reset;
   logic         a_valid, a_ready, a_start, a_done, a_busy, a_sent, a_err;
   logic [127:0] a_data;
   logic [7:0]   a_txd;
   logic         b_valid, b_ready, b_start, b_done, b_busy, b_sent, b_err;
   logic [31:0]  b_data;
   logic [7:0]   b_txd;

   logic [127:0] blk_exp;
   logic [127:0] blk_exp2;
   logic [31:0]  bexp;
   int total = 0;
   int bad = 0;
   int cyc = 0;
   int a_sents = 0;
   int b_sents = 0;
   int t_done;
   int t0;
   int n;

   block_tx_framer u_a (
      .clk(clk), .reset(reset), .blk_valid(a_valid), .blk_data(a_data),
      .blk_ready(a_ready), .tx_start(a_start), .tx_data(a_txd), .tx_done(a_done),
      .busy(a_busy), .blk_sent(a_sent), .tx_err(a_err)
   );

   block_tx_framer #(.NUM_BYTES(4), .GAP_CYCLES(3), .TIMEOUT_CYCLES(50)) u_b (
      .clk(clk), .reset(reset), .blk_valid(b_valid), .blk_data(b_data),
      .blk_ready(b_ready), .tx_start(b_start), .tx_data(b_txd), .tx_done(b_done),
      .busy(b_busy), .blk_sent(b_sent), .tx_err(b_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (a_sent === 1'b1) a_sents <= a_sents + 1;
      if (b_sent === 1'b1) b_sents <= b_sents + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_start(input bit use_b, input string tag);
      int k = 0;
      while (((use_b ? b_start : a_start) !== 1'b1) && (k < 200)) begin
         @(negedge clk);
         k++;
      end
      chk(tag, 32'(use_b ? b_start : a_start), 32'd1);
   endtask

   task automatic a_xfer(input logic [7:0] exp, input int dly);
      wait_start(1'b0, "a_start_seen");
      chk("a_txd", 32'(a_txd), 32'(exp));
      @(negedge clk);
      chk("a_start_one_cycle", 32'(a_start), 32'd0);
      repeat (dly - 2) @(negedge clk);
      chk("a_txd_hold", 32'(a_txd), 32'(exp));
      a_done = 1'b1;
      @(negedge clk);
      a_done = 1'b0;
   endtask

   initial begin
      blk_exp  = 128'h00112233445566778899AABBCCDDEEFF;
      blk_exp2 = 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F;
      bexp     = 32'hDEADBEEF;
      reset = 1'b0;
      a_valid = 1'b0; a_done = 1'b0; a_data = '0;
      b_valid = 1'b0; b_done = 1'b0; b_data = '0;

      // Reset values
      repeat (2) @(negedge clk);
      chk("rst_a_ready", 32'(a_ready), 32'd0);
      chk("rst_a_start", 32'(a_start), 32'd0);
      chk("rst_a_txd", 32'(a_txd), 32'h00);
      chk("rst_a_busy", 32'(a_busy), 32'd0);
      chk("rst_a_sent", 32'(a_sent), 32'd0);
      chk("rst_a_err", 32'(a_err), 32'd0);
      chk("rst_b_ready", 32'(b_ready), 32'd0);
      reset = 1'b1;
      @(negedge clk);
      chk("a_ready_after_rst", 32'(a_ready), 32'd1);
      chk("b_ready_after_rst", 32'(b_ready), 32'd1);

      // 16-byte block, 20-cycle UART, mid-block valid toggle, held tx_done
      a_data = blk_exp; a_valid = 1'b1;
      @(negedge clk);
      a_valid = 1'b0;
      chk("a_busy_accept", 32'(a_busy), 32'd1);
      chk("a_ready_accept", 32'(a_ready), 32'd0);
      for (int i = 0; i < 16; i++) begin
         if (i == 3) begin
            a_valid = 1'b1;
            a_data  = {16{8'hA5}};
         end
         if (i == 5) begin
            wait_start(1'b0, "a_start_seen");
            chk("a_txd", 32'(a_txd), 32'(blk_exp[127-8*i -: 8]));
            repeat (19) @(negedge clk);
            a_done = 1'b1;
            @(negedge clk);
         end else if (i == 6) begin
            wait_start(1'b0, "a_start_seen");
            chk("a_txd", 32'(a_txd), 32'(blk_exp[127-8*i -: 8]));
            repeat (19) begin
               @(negedge clk);
               chk("a_level_no_retrig", 32'(a_start), 32'd0);
            end
            a_done = 1'b0;
            @(negedge clk);
            a_done = 1'b1;
            @(negedge clk);
            a_done = 1'b0;
         end else begin
            a_xfer(blk_exp[127-8*i -: 8], 20);
         end
         if (i == 3) a_valid = 1'b0;
      end
      chk("a_sent_pulse", 32'(a_sent), 32'd1);
      chk("a_ready_end", 32'(a_ready), 32'd1);
      chk("a_busy_end", 32'(a_busy), 32'd0);
      @(negedge clk);
      chk("a_sent_one_cycle", 32'(a_sent), 32'd0);
      chk("a_sent_count", 32'(a_sents), 32'd1);

      // 4-byte block with a 3-cycle gap
      b_data = bexp; b_valid = 1'b1;
      @(negedge clk);
      b_valid = 1'b0;
      t_done = 0;
      for (int i = 0; i < 4; i++) begin
         wait_start(1'b1, "b_start_seen");
         chk("b_txd", 32'(b_txd), 32'(bexp[31-8*i -: 8]));
         if (i > 0) chk("b_gap_period", 32'(cyc - t_done), 32'd4);
         repeat (5) @(negedge clk);
         t_done = cyc;
         b_done = 1'b1;
         @(negedge clk);
         b_done = 1'b0;
      end
      chk("b_sent_pulse", 32'(b_sent), 32'd1);
      chk("b_busy_in_gap", 32'(b_busy), 32'd1);
      repeat (2) @(negedge clk);
      chk("b_ready_during_gap", 32'(b_ready), 32'd0);
      @(negedge clk);
      chk("b_ready_after_gap", 32'(b_ready), 32'd1);
      chk("b_busy_after_gap", 32'(b_busy), 32'd0);

      // Timeout with tx_done stuck low
      b_data = 32'h11223344; b_valid = 1'b1;
      @(negedge clk);
      b_valid = 1'b0;
      wait_start(1'b1, "b_start_seen");
      t0 = cyc;
      n = 0;
      while ((b_err !== 1'b1) && (n < 200)) begin
         @(negedge clk);
         n++;
      end
      chk("b_err_seen", 32'(b_err), 32'd1);
      chk("b_timeout_cycles", 32'(cyc - t0), 32'd50);
      chk("b_ready_after_err", 32'(b_ready), 32'd1);
      chk("b_busy_after_err", 32'(b_busy), 32'd0);
      @(negedge clk);
      chk("b_err_one_cycle", 32'(b_err), 32'd0);
      chk("b_sent_count", 32'(b_sents), 32'd1);

      // Asynchronous reset during byte 5, then restart from byte 0
      a_data = blk_exp2; a_valid = 1'b1;
      @(negedge clk);
      a_valid = 1'b0;
      for (int i = 0; i < 5; i++) a_xfer(blk_exp2[127-8*i -: 8], 3);
      wait_start(1'b0, "a_start_seen");
      chk("a_txd_byte5", 32'(a_txd), 32'(blk_exp2[87:80]));
      #2 reset = 1'b0;
      #1;
      chk("arst_a_start", 32'(a_start), 32'd0);
      chk("arst_a_txd", 32'(a_txd), 32'h00);
      chk("arst_a_busy", 32'(a_busy), 32'd0);
      chk("arst_a_ready", 32'(a_ready), 32'd0);
      chk("arst_a_sent", 32'(a_sent), 32'd0);
      chk("arst_a_err", 32'(a_err), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("a_ready_after_arst", 32'(a_ready), 32'd1);
      chk("a_busy_after_arst", 32'(a_busy), 32'd0);
      a_data = blk_exp; a_valid = 1'b1;
      @(negedge clk);
      a_valid = 1'b0;
      wait_start(1'b0, "a_start_seen");
      chk("a_restart_byte0", 32'(a_txd), 32'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
